// File: rtl/top_gray_pkg.sv
// ---------------------------------------------------------------------------
// top_gray_pkg
// Shared constants and types for the grayscale multiply-accumulate slice.
//   PROD_W   : signed product width delivered by the DSP multiplier
//   ACC_W    : accumulator width (headroom for the tap sum)
//   SHIFT    : fractional bits dropped after rounding (Q12 coefficients)
//   PIX_MAX  : largest representable output pixel
//   LUMA_*   : Q12 luma coefficients fed to the upstream multiplier
//   state_t  : accumulate / output-hold states of the MAC controller
// ---------------------------------------------------------------------------
package top_gray_pkg;

  localparam int PROD_W  = 28;
  localparam int ACC_W   = 30;
  localparam int SHIFT   = 12;
  localparam int PIX_MAX = 255;

  localparam int LUMA_R = 1225;
  localparam int LUMA_G = 2404;
  localparam int LUMA_B = 467;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

endpackage

// File: rtl/top_gray_round_sat.sv
// ---------------------------------------------------------------------------
// top_gray_round_sat
// Combinational round-half-up, arithmetic right shift and clamp of a signed
// accumulator sum into an unsigned 8-bit pixel.
// Ports:
//   sum : signed ACC_W-bit tap sum
//   pix : clamped pixel, 0..PIX_MAX
//   sat : high when the rounded value had to be clamped to 0 or PIX_MAX
// ---------------------------------------------------------------------------
module top_gray_round_sat
  import top_gray_pkg::*;
#(
  parameter int ACC_W = top_gray_pkg::ACC_W,
  parameter int SHIFT = top_gray_pkg::SHIFT
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [7:0]       pix,
  output logic                    sat
);

  // One extra bit keeps the rounding offset from overflowing a sum that
  // already sits near the top of the accumulator range.
  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAX_VAL = (ACC_W+1)'(PIX_MAX);

  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  // Round half up, then drop the fractional bits keeping the sign.
  always_comb begin
    rounded = {sum[ACC_W-1], sum} + HALF;
    shifted = rounded >>> SHIFT;
  end

  // Clamp into the pixel range and flag any clamp as a saturation event.
  always_comb begin
    pix = shifted[7:0];
    sat = 1'b0;
    if (shifted < 0) begin
      pix = 8'd0;
      sat = 1'b1;
    end else if (shifted > MAX_VAL) begin
      pix = 8'(PIX_MAX);
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/top_gray_mac_acc.sv
// ---------------------------------------------------------------------------
// top_gray_mac_acc
// Accumulates TAPS consecutive signed products, then rounds, shifts and
// clamps the sum into an 8-bit pixel. Ready/valid on both sides; a held,
// unaccepted pixel stalls the product input.
// Optional feature: define TOP_GRAY_MAC_SAT_CNT_EN to add the saturating
// sat_cnt output counting clamped pixels.
// Ports:
//   ap_clk, ap_rst          : clock (rising edge), async active-high reset
//   prod_data/valid/ready   : signed product input stream
//   pix_data/valid/ready    : unsigned pixel output stream
//   sat_cnt                 : clamp event count (optional feature only)
// ---------------------------------------------------------------------------
module top_gray_mac_acc
  import top_gray_pkg::*;
#(
  parameter int TAPS   = 3,
  parameter int PROD_W = top_gray_pkg::PROD_W,
  parameter int ACC_W  = top_gray_pkg::ACC_W,
  parameter int SHIFT  = top_gray_pkg::SHIFT
`ifdef TOP_GRAY_MAC_SAT_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready
`ifdef TOP_GRAY_MAC_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0]  sat_cnt
`endif
);

  localparam int CNT_BITS = $clog2(TAPS);

  // Refuse to build configurations where the tap sum could wrap.
  if (ACC_W < PROD_W + $clog2(TAPS)) begin : g_acc_w_check
    $error("top_gray_mac_acc: ACC_W too narrow for PROD_W and TAPS");
  end
  if (TAPS < 2) begin : g_taps_check
    $error("top_gray_mac_acc: TAPS must be at least 2");
  end
  if (SHIFT < 1) begin : g_shift_check
    $error("top_gray_mac_acc: SHIFT must be at least 1");
  end

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_BITS-1:0]       cnt;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic                      beat;
  logic                      last_beat;
  logic                      pix_take;
  logic [7:0]                rs_pix;
  logic                      rs_sat;

  // Input is blocked only while a finished pixel waits on downstream, so
  // groups run back to back whenever pix_ready stays high.
  always_comb begin
    prod_ready = !(pix_valid && !pix_ready);
    beat       = prod_valid && prod_ready;
    pix_take   = pix_valid && pix_ready;
    last_beat  = beat && (cnt == CNT_BITS'(TAPS - 1));
    prod_ext   = {{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data};
    sum        = acc + prod_ext;
  end

  top_gray_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .sum (sum),
    .pix (rs_pix),
    .sat (rs_sat)
  );

  // Controller: accumulate taps, register the pixel on the final tap and
  // hold it until accepted. A beat accepted while the pixel is consumed
  // simply starts the next group from a cleared accumulator.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= S_ACC;
      acc       <= '0;
      cnt       <= '0;
      pix_data  <= 8'd0;
      pix_valid <= 1'b0;
    end else begin
      if (pix_take) begin
        pix_valid <= 1'b0;
      end
      if (beat) begin
        if (last_beat) begin
          acc       <= '0;
          cnt       <= '0;
          pix_data  <= rs_pix;
          pix_valid <= 1'b1;
          state     <= S_OUT;
        end else begin
          acc   <= sum;
          cnt   <= cnt + 1'b1;
          state <= S_ACC;
        end
      end else if (pix_take) begin
        state <= S_ACC;
      end
    end
  end

`ifdef TOP_GRAY_MAC_SAT_CNT_EN
  // Count clamped pixels as they are registered; stick at all-ones.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sat_cnt <= '0;
    end else if (last_beat && rs_sat && (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end
`else
  logic sat_unused;
  assign sat_unused = rs_sat;
`endif

endmodule
